// File: rtl/meas_aggregator.sv
// Measurement frame sequencer: on each PWM trigger, runs two ADC1 conversions (pos/neg) and one ADC2 conversion,
// then publishes Vfc = Vpos - Vneg (clamped at 0) and Vout with a one-cycle valid strobe. A watchdog aborts stuck frames.
module meas_aggregator #(
  parameter logic [1:0]  CH_POS         = 2'd0,
  parameter logic [1:0]  CH_NEG         = 2'd2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trig_i,
  output logic        adc1_en_o,
  output logic [1:0]  adc1_ch_o,
  input  logic [15:0] adc1_data_i,
  input  logic        adc1_drdy_i,
  output logic        adc2_en_o,
  input  logic [15:0] adc2_data_i,
  input  logic        adc2_drdy_i,
  output logic [15:0] vfc_o,
  output logic [15:0] vout_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        overrun_o,
  output logic        timeout_o,
  output logic        fault_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_POS  = 3'd1,
    S_ISSUE_NEG = 3'd2,
    S_WAIT_NEG  = 3'd3,
    S_PUBLISH   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_pos;
  logic [15:0]   r_neg;
  logic [15:0]   r_vout_cap;
  logic          r_adc1_done;
  logic          r_adc2_done;
  logic          r_adc1_en;
  logic          r_adc2_en;
  logic [1:0]    r_ch;
  logic [15:0]   r_vfc;
  logic [15:0]   r_vout;
  logic          r_valid;
  logic          r_overrun;
  logic          r_timeout;
  logic          r_fault;

  logic          w_busy;
  logic          w_to_hit;
  logic          w_start;
  logic          w_issue_neg;
  logic          w_cap_pos;
  logic          w_cap_neg;
  logic          w_cap_vout;
  logic          w_publish;
  logic          w_timeout;
  logic          w_overrun;
  logic [15:0]   w_diff;

  assign w_busy   = (r_state != S_IDLE);
  assign w_to_hit = (r_cnt == TO_LAST);
  assign w_diff   = (r_pos >= r_neg) ? (r_pos - r_neg) : 16'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Completion is tested before the watchdog so a frame finishing on the last allowed cycle still publishes.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_issue_neg = 1'b0;
    w_cap_pos   = 1'b0;
    w_cap_neg   = 1'b0;
    w_publish   = 1'b0;
    w_timeout   = 1'b0;
    w_overrun   = trig_i && w_busy;
    w_cap_vout  = adc2_drdy_i && w_busy && !r_adc2_done;
    case (r_state)
      S_IDLE: begin
        if (trig_i) begin
          w_start = 1'b1;
          w_next  = S_WAIT_POS;
        end
      end
      S_WAIT_POS: begin
        if (w_to_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else if (adc1_drdy_i) begin
          w_cap_pos = 1'b1;
          w_next    = S_ISSUE_NEG;
        end
      end
      S_ISSUE_NEG: begin
        if (w_to_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_issue_neg = 1'b1;
          w_next      = S_WAIT_NEG;
        end
      end
      S_WAIT_NEG: begin
        if (r_adc1_done && r_adc2_done) begin
          w_next = S_PUBLISH;
        end else if (w_to_hit) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end else if (adc1_drdy_i && !r_adc1_done) begin
          w_cap_neg = 1'b1;
        end
      end
      S_PUBLISH: begin
        w_publish = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt       <= '0;
      r_pos       <= 16'd0;
      r_neg       <= 16'd0;
      r_vout_cap  <= 16'd0;
      r_adc1_done <= 1'b0;
      r_adc2_done <= 1'b0;
      r_adc1_en   <= 1'b0;
      r_adc2_en   <= 1'b0;
      r_ch        <= CH_POS;
      r_vfc       <= 16'd0;
      r_vout      <= 16'd0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_adc1_en <= w_start | w_issue_neg;
      r_adc2_en <= w_start;
      r_valid   <= w_publish;
      r_overrun <= w_overrun;
      r_timeout <= w_timeout;
      if (w_timeout) r_fault <= 1'b1;

      if (w_start) begin
        r_cnt       <= '0;
        r_ch        <= CH_POS;
        r_adc1_done <= 1'b0;
        r_adc2_done <= 1'b0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_cap_pos) begin
        r_pos <= adc1_data_i;
        r_ch  <= CH_NEG;
      end
      if (w_cap_neg) begin
        r_neg       <= adc1_data_i;
        r_adc1_done <= 1'b1;
      end
      if (w_cap_vout) begin
        r_vout_cap  <= adc2_data_i;
        r_adc2_done <= 1'b1;
      end
      if (w_publish) begin
        r_vfc  <= w_diff;
        r_vout <= r_vout_cap;
      end
    end
  end

  assign adc1_en_o = r_adc1_en;
  assign adc2_en_o = r_adc2_en;
  assign adc1_ch_o = r_ch;
  assign vfc_o     = r_vfc;
  assign vout_o    = r_vout;
  assign valid_o   = r_valid;
  assign busy_o    = w_busy;
  assign overrun_o = r_overrun;
  assign timeout_o = r_timeout;
  assign fault_o   = r_fault;

endmodule

// File: tb/tb_meas_aggregator.sv
// Bench for meas_aggregator: a timestamp-based frame model predicts every output each cycle,
// plus directed frames with hand-computed literal results.
module tb_meas_aggregator;

  localparam int T = 100;
  localparam logic [1:0] CH_POS = 2'd0;
  localparam logic [1:0] CH_NEG = 2'd2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        trig_i;
  logic        adc1_en_o;
  logic [1:0]  adc1_ch_o;
  logic [15:0] adc1_data_i;
  logic        adc1_drdy_i;
  logic        adc2_en_o;
  logic [15:0] adc2_data_i;
  logic        adc2_drdy_i;
  logic [15:0] vfc_o;
  logic [15:0] vout_o;
  logic        valid_o;
  logic        busy_o;
  logic        overrun_o;
  logic        timeout_o;
  logic        fault_o;

  int n_tests = 0;
  int n_fail  = 0;

  meas_aggregator #(
    .CH_POS(CH_POS), .CH_NEG(CH_NEG), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .trig_i(trig_i),
    .adc1_en_o(adc1_en_o), .adc1_ch_o(adc1_ch_o), .adc1_data_i(adc1_data_i), .adc1_drdy_i(adc1_drdy_i),
    .adc2_en_o(adc2_en_o), .adc2_data_i(adc2_data_i), .adc2_drdy_i(adc2_drdy_i),
    .vfc_o(vfc_o), .vout_o(vout_o), .valid_o(valid_o), .busy_o(busy_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o), .fault_o(fault_o)
  );

  // ---------------- clock / global bound ----------------
  initial forever #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL global_time_limit: simulation did not finish, got no end, required end before 100000");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- model: each frame as a set of edge timestamps ----------------
  // cyc numbers posedges; s = trigger edge, p/q = pos/neg accept edges, v = vout accept edge.
  // Results publish two edges after the later of q and v; otherwise the frame dies at edge s+T.
  int          cyc = 0;
  int          m_s = -1000, m_p = -1, m_q = -1, m_v = -1, m_pub = -1;
  bit          m_active = 1'b0;
  logic [15:0] m_pos = 16'd0, m_neg = 16'd0, m_vcap = 16'd0;
  logic [15:0] e_vfc = 16'd0, e_vout = 16'd0;
  logic [1:0]  e_ch = 2'd0;
  bit          e_fault = 1'b0, e_valid = 1'b0, e_timeout = 1'b0, e_overrun = 1'b0;
  bit          e_en1 = 1'b0, e_en2 = 1'b0;

  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (!rst_ni) begin
      m_active = 1'b0; m_s = -1000; m_p = -1; m_q = -1; m_v = -1; m_pub = -1;
      e_vfc = 16'd0; e_vout = 16'd0; e_fault = 1'b0; e_valid = 1'b0; e_timeout = 1'b0;
      e_overrun = 1'b0; e_en1 = 1'b0; e_en2 = 1'b0; e_ch = CH_POS;
    end else begin
      e_overrun = trig_i && m_active;
      e_valid   = 1'b0;
      e_timeout = 1'b0;
      if (m_active) begin
        if (cyc < m_s + T) begin
          if (m_p < 0 && adc1_drdy_i) begin
            m_p = cyc; m_pos = adc1_data_i;
          end else if (m_p >= 0 && m_q < 0 && cyc >= m_p + 2 && adc1_drdy_i) begin
            m_q = cyc; m_neg = adc1_data_i;
          end
          if (m_v < 0 && adc2_drdy_i) begin
            m_v = cyc; m_vcap = adc2_data_i;
          end
          if (m_q >= 0 && m_v >= 0 && m_pub < 0) m_pub = ((m_q > m_v) ? m_q : m_v) + 2;
        end
        if (m_pub >= 0 && cyc == m_pub) begin
          e_valid  = 1'b1;
          e_vfc    = (m_pos >= m_neg) ? m_pos - m_neg : 16'd0;
          e_vout   = m_vcap;
          m_active = 1'b0;
        end else if (m_pub < 0 && cyc == m_s + T) begin
          e_timeout = 1'b1;
          e_fault   = 1'b1;
          m_active  = 1'b0;
        end
      end else if (trig_i) begin
        m_active = 1'b1; m_s = cyc; m_p = -1; m_q = -1; m_v = -1; m_pub = -1;
      end
      e_en1 = (cyc == m_s) || (m_p >= 0 && cyc == m_p + 1 && cyc < m_s + T);
      e_en2 = (cyc == m_s);
      e_ch  = (m_p >= 0 && cyc >= m_p) ? CH_NEG : CH_POS;
    end
  end

  // ---------------- per-cycle compare + pulse counters ----------------
  int cnt_en1 = 0, cnt_en2 = 0, cnt_valid = 0, cnt_ovr = 0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      check("rst_vfc", 32'(vfc_o), 32'd0);
      check("rst_vout", 32'(vout_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_fault", 32'(fault_o), 32'd0);
      check("rst_ch", 32'(adc1_ch_o), 32'(CH_POS));
    end else begin
      check("cmp_vfc", 32'(vfc_o), 32'(e_vfc));
      check("cmp_vout", 32'(vout_o), 32'(e_vout));
      check("cmp_valid", 32'(valid_o), 32'(e_valid));
      check("cmp_busy", 32'(busy_o), 32'(m_active));
      check("cmp_overrun", 32'(overrun_o), 32'(e_overrun));
      check("cmp_timeout", 32'(timeout_o), 32'(e_timeout));
      check("cmp_fault", 32'(fault_o), 32'(e_fault));
      check("cmp_en1", 32'(adc1_en_o), 32'(e_en1));
      check("cmp_en2", 32'(adc2_en_o), 32'(e_en2));
      check("cmp_ch", 32'(adc1_ch_o), 32'(e_ch));
      if (adc1_en_o) cnt_en1 = cnt_en1 + 1;
      if (adc2_en_o) cnt_en2 = cnt_en2 + 1;
      if (valid_o)   cnt_valid = cnt_valid + 1;
      if (overrun_o) cnt_ovr = cnt_ovr + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic trig_pulse();
    trig_i = 1'b1; tick(); trig_i = 1'b0;
  endtask

  task automatic adc1_resp(input logic [15:0] d);
    adc1_data_i = d; adc1_drdy_i = 1'b1; tick(); adc1_drdy_i = 1'b0;
  endtask

  task automatic adc2_resp(input logic [15:0] d);
    adc2_data_i = d; adc2_drdy_i = 1'b1; tick(); adc2_drdy_i = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (valid_o !== 1'b1 && k < 20) begin
      tick();
      k = k + 1;
    end
    check(name, 32'(valid_o), 32'd1);
  endtask

  task automatic run_frame(input logic [15:0] pos, input logic [15:0] neg, input logic [15:0] v, input string name);
    trig_pulse();
    adc2_resp(v);
    adc1_resp(pos);
    tick(); tick();
    adc1_resp(neg);
    wait_valid(name);
  endtask

  // ---------------- directed sequence ----------------
  int b_en1, b_en2, b_val, b_ovr, s_edge, k;

  initial begin
    rst_ni = 1'b0; trig_i = 1'b0;
    adc1_data_i = 16'd0; adc1_drdy_i = 1'b0; adc2_data_i = 16'd0; adc2_drdy_i = 1'b0;
    tick(); tick();
    check("reset_ch", 32'(adc1_ch_o), 32'(CH_POS));
    check("reset_busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // 1: nominal frame
    b_en1 = cnt_en1; b_en2 = cnt_en2; b_val = cnt_valid;
    trig_pulse();
    check("t1_en1_first", 32'(adc1_en_o), 32'd1);
    check("t1_en2", 32'(adc2_en_o), 32'd1);
    check("t1_ch_pos", 32'(adc1_ch_o), 32'd0);
    tick(); tick();
    adc2_resp(16'h4CCE);
    tick();
    adc1_resp(16'h8000);
    check("t1_ch_neg", 32'(adc1_ch_o), 32'd2);
    tick();
    check("t1_en1_second", 32'(adc1_en_o), 32'd1);
    tick(); tick();
    adc1_resp(16'h1670);
    tick();
    check("t1_valid_not_early", 32'(valid_o), 32'd0);
    tick();
    check("t1_valid_lat2", 32'(valid_o), 32'd1);
    check("t1_vfc", 32'(vfc_o), 32'h6990);
    check("t1_vout", 32'(vout_o), 32'h4CCE);
    check("t1_model_vfc", 32'(e_vfc), 32'h6990);
    tick();
    check("t1_valid_one_cycle", 32'(valid_o), 32'd0);
    check("t1_en1_count", 32'(cnt_en1 - b_en1), 32'd2);
    check("t1_en2_count", 32'(cnt_en2 - b_en2), 32'd1);
    check("t1_valid_count", 32'(cnt_valid - b_val), 32'd1);

    // 3a: underflow clamps to zero
    run_frame(16'h1000, 16'h2000, 16'h1234, "t3a_valid");
    check("t3a_vfc", 32'(vfc_o), 32'h0000);
    check("t3a_vout", 32'(vout_o), 32'h1234);
    tick();

    // 2a: ADC2 arrives 50 cycles after ADC1 completes
    trig_pulse();
    adc1_resp(16'h9000);
    tick(); tick();
    adc1_resp(16'h1000);
    b_val = cnt_valid;
    repeat (50) tick();
    check("t2a_still_busy", 32'(busy_o), 32'd1);
    check("t2a_no_valid_yet", 32'(cnt_valid - b_val), 32'd0);
    adc2_resp(16'h0ABC);
    tick();
    check("t2a_valid_not_early", 32'(valid_o), 32'd0);
    tick();
    check("t2a_valid_lat2", 32'(valid_o), 32'd1);
    check("t2a_vfc", 32'(vfc_o), 32'h8000);
    check("t2a_vout", 32'(vout_o), 32'h0ABC);
    tick();

    // 3b: equal inputs give zero
    run_frame(16'h7FFF, 16'h7FFF, 16'h2222, "t3b_valid");
    check("t3b_vfc", 32'(vfc_o), 32'h0000);
    check("t3b_vout", 32'(vout_o), 32'h2222);
    tick();

    // 2b: neg drdy and ADC2 drdy in the same cycle
    b_val = cnt_valid;
    trig_pulse();
    adc1_resp(16'h0005);
    tick(); tick();
    adc1_data_i = 16'h0003; adc1_drdy_i = 1'b1;
    adc2_data_i = 16'hFFFF; adc2_drdy_i = 1'b1;
    tick();
    adc1_drdy_i = 1'b0; adc2_drdy_i = 1'b0;
    tick();
    check("t2b_valid_not_early", 32'(valid_o), 32'd0);
    tick();
    check("t2b_valid_lat2", 32'(valid_o), 32'd1);
    check("t2b_vfc", 32'(vfc_o), 32'h0002);
    check("t2b_vout", 32'(vout_o), 32'hFFFF);
    repeat (3) tick();
    check("t2b_single_valid", 32'(cnt_valid - b_val), 32'd1);

    // 4: ADC2 never answers -> watchdog
    b_val = cnt_valid;
    trig_pulse();
    s_edge = cyc;
    adc1_resp(16'h0400);
    tick(); tick();
    adc1_resp(16'h0100);
    k = 0;
    while (timeout_o !== 1'b1 && k < 150) begin
      tick();
      k = k + 1;
    end
    check("t4_timeout_seen", 32'(timeout_o), 32'd1);
    check("t4_timeout_edge", 32'(cyc - s_edge), 32'(T));
    check("t4_fault", 32'(fault_o), 32'd1);
    check("t4_busy_cleared", 32'(busy_o), 32'd0);
    check("t4_vfc_held", 32'(vfc_o), 32'h0002);
    check("t4_vout_held", 32'(vout_o), 32'hFFFF);
    check("t4_no_valid", 32'(cnt_valid - b_val), 32'd0);
    tick();
    check("t4_timeout_one_cycle", 32'(timeout_o), 32'd0);
    run_frame(16'h0100, 16'h0080, 16'h0333, "t4_clean_valid");
    check("t4_clean_vfc", 32'(vfc_o), 32'h0080);
    check("t4_clean_vout", 32'(vout_o), 32'h0333);
    check("t4_fault_sticky", 32'(fault_o), 32'd1);
    tick();

    // 5: overrun in WAIT_NEG, drdy in ISSUE_NEG ignored, stray drdy in IDLE
    b_en1 = cnt_en1; b_en2 = cnt_en2; b_ovr = cnt_ovr;
    trig_pulse();
    adc1_resp(16'h3000);
    adc1_data_i = 16'hFFFF; adc1_drdy_i = 1'b1;
    tick();
    adc1_drdy_i = 1'b0;
    check("t5_en1_second", 32'(adc1_en_o), 32'd1);
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    check("t5_overrun", 32'(overrun_o), 32'd1);
    check("t5_no_extra_en2", 32'(adc2_en_o), 32'd0);
    tick();
    check("t5_overrun_one_cycle", 32'(overrun_o), 32'd0);
    adc2_resp(16'h0777);
    adc1_resp(16'h1000);
    wait_valid("t5_valid");
    check("t5_vfc", 32'(vfc_o), 32'h2000);
    check("t5_vout", 32'(vout_o), 32'h0777);
    tick();
    check("t5_en1_count", 32'(cnt_en1 - b_en1), 32'd2);
    check("t5_en2_count", 32'(cnt_en2 - b_en2), 32'd1);
    check("t5_ovr_count", 32'(cnt_ovr - b_ovr), 32'd1);
    b_val = cnt_valid;
    adc1_resp(16'h1111);
    adc2_resp(16'h2222);
    repeat (5) tick();
    check("t5_idle_no_valid", 32'(cnt_valid - b_val), 32'd0);
    check("t5_idle_vfc", 32'(vfc_o), 32'h2000);

    // 6: reset in WAIT_NEG
    trig_pulse();
    adc1_resp(16'h5000);
    tick(); tick();
    check("t6_ch_neg", 32'(adc1_ch_o), 32'd2);
    check("t6_busy", 32'(busy_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_ch", 32'(adc1_ch_o), 32'(CH_POS));
    check("t6_rst_vfc", 32'(vfc_o), 32'd0);
    check("t6_rst_vout", 32'(vout_o), 32'd0);
    check("t6_rst_fault", 32'(fault_o), 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    b_val = cnt_valid;
    adc1_resp(16'h0001);
    adc2_resp(16'h0002);
    repeat (5) tick();
    check("t6_post_no_valid", 32'(cnt_valid - b_val), 32'd0);
    check("t6_post_busy", 32'(busy_o), 32'd0);
    check("t6_post_vfc", 32'(vfc_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
